reg_writeback: RTL

- Writeback stage directly upstream of the register file.
- Accepts results from two functional units, ALU/load and FPU, through valid/ready handshakes, arbitrating one write per cycle.
- Drives the register file's flattened data vector and per-register enable vector.
- Keeps a scoreboard of registers with pending writes, so issue stalls on write-after-write hazards.

---
 rtl/reg_writeback_pkg.sv | 32 +++
 rtl/reg_writeback_arbiter.sv | 47 ++++
 rtl/reg_writeback.sv | 104 ++++++++++
 3 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the writeback stage: default geometry of the
// register file and the source encoding used by the writeback arbiter.
package reg_writeback_pkg;

  // Register file geometry shared with the register file itself.
  localparam int DEF_WIDTH = 32;  // bits per register
  localparam int DEF_NUM   = 64;  // r0..r31 at 0..31, f0..f31 at 32..63
  localparam int DEF_IDXW  = 6;   // ceil(log2(DEF_NUM))

  // Identifies which functional unit owns a writeback slot.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_FPU = 1'b1
  } wb_src_e;

  // Round-robin pick between two requesters. The source that did not win
  // most recently is preferred when both request; a lone requester wins.
  function automatic wb_src_e rr_pick(input logic    alu_req,
                                      input logic    fpu_req,
                                      input wb_src_e last);
    wb_src_e pick;
    if (alu_req && fpu_req) begin
      pick = (last == SRC_ALU) ? SRC_FPU : SRC_ALU;
    end else if (fpu_req) begin
      pick = SRC_FPU;
    end else begin
      pick = SRC_ALU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_writeback_arbiter.sv
// Two-input round-robin arbiter for the writeback port. Produces at most one
// grant per cycle and remembers which source was granted last so that two
// persistent requesters alternate.
//
// Handshake: a transfer happens in a cycle where valid and ready are both
// high. A requester raises valid with stable payload and keeps it (and the
// payload) unchanged until it sees ready; ready here is exactly the grant
// and may depend combinationally on the valids.
module wb_arbiter
  import reg_writeback_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    alu_valid,
  input  logic    fpu_valid,
  output logic    grant_alu,
  output logic    grant_fpu,
  output wb_src_e last_grant
);

  wb_src_e pick;

  // Grant selection; nothing is granted while reset is asserted so that an
  // in-flight result is not consumed in the reset cycle.
  always_comb begin
    pick      = rr_pick(alu_valid, fpu_valid, last_grant);
    grant_alu = 1'b0;
    grant_fpu = 1'b0;
    if (rstn) begin
      grant_alu = alu_valid && (pick == SRC_ALU);
      grant_fpu = fpu_valid && (pick == SRC_FPU);
    end
  end

  // Last-grant pointer; reset to FPU so the ALU is favoured first. It only
  // moves on a real grant.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant <= SRC_FPU;
    end else if (grant_alu) begin
      last_grant <= SRC_ALU;
    end else if (grant_fpu) begin
      last_grant <= SRC_FPU;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage in front of the register file. Arbitrates ALU/load and FPU
// results into one register write per cycle, drives the register file's
// replicated data vector and one-hot enable, and tracks pending writes in a
// scoreboard so issue stalls on write-after-write hazards.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM   = DEF_NUM,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 issue_valid,
  input  logic [IDXW-1:0]      issue_rd,
  output logic                 issue_ready,
  input  logic                 alu_valid,
  input  logic [IDXW-1:0]      alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  output logic                 alu_ready,
  input  logic                 fpu_valid,
  input  logic [IDXW-1:0]      fpu_rd,
  input  logic [WIDTH-1:0]     fpu_data,
  output logic                 fpu_ready,
  output logic [WIDTH*NUM-1:0] inreg,
  output logic [NUM-1:0]       enable,
  output logic [NUM-1:0]       busy
);

  logic             grant_alu;
  logic             grant_fpu;
  wb_src_e          arb_last;
  logic             accept;
  logic [IDXW-1:0]  sel_rd;
  logic [WIDTH-1:0] sel_data;
  logic [NUM-1:0]   set_mask;
  logic [NUM-1:0]   wr_onehot;

  wb_arbiter u_arbiter (
    .clk        (clk),
    .rstn       (rstn),
    .alu_valid  (alu_valid),
    .fpu_valid  (fpu_valid),
    .grant_alu  (grant_alu),
    .grant_fpu  (grant_fpu),
    .last_grant (arb_last)
  );

  assign alu_ready = grant_alu;
  assign fpu_ready = grant_fpu;
  assign accept    = grant_alu | grant_fpu;

  // r0 is hardwired, so it never blocks issue.
  assign issue_ready = ~busy[issue_rd] | (issue_rd == '0);

  // Select the granted result and decode its destination; r0 decodes to no
  // enable at all.
  always_comb begin
    sel_rd    = alu_rd;
    sel_data  = alu_data;
    wr_onehot = '0;
    if (grant_fpu) begin
      sel_rd   = fpu_rd;
      sel_data = fpu_data;
    end
    if (accept && (sel_rd != '0)) begin
      wr_onehot[sel_rd] = 1'b1;
    end
  end

  // Scoreboard bit to set for an accepted reservation of a non-zero register.
  always_comb begin
    set_mask = '0;
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      set_mask[issue_rd] = 1'b1;
    end
  end

  // Output registers: enable pulses for one cycle after an accept, data is
  // broadcast to every slot and held when nothing is written.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      enable <= '0;
      inreg  <= '0;
    end else begin
      enable <= wr_onehot;
      if (accept) begin
        inreg <= {NUM{sel_data}};
      end
    end
  end

  // Scoreboard: a bit clears when its enable pulse lands in the register
  // file and sets on a reservation; set and clear of one bit cannot coincide
  // because issue is refused while the bit is set. Bit 0 stays low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~enable) | set_mask) & ~{{(NUM-1){1'b0}}, 1'b1};
    end
  end

endmodule
